// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI target, all cpol/cpha modes, 1-32 bit MSB-first frames, AXI-Stream rx/tx; define SPI_SLAVE_RX_OVERFLOW_EN for sticky rx_overflow
module spi_slave #(
  parameter int sync_stages = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [5:0]  frame_width,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
  output logic        rx_overflow,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_next;
  logic [sync_stages-1:0] cs_q, sck_q, mosi_q;
  logic cs_s, sck_s, mosi_s, sck_d;
  logic cpol_r, cpha_r;
  logic [5:0] fw_r, fw_eff, fw_use, cnt, sh;
  logic [30:0] rx_sr;
  logic [31:0] tx_sr, tx_word, tx_al, rx_word, buf_data;
  logic buf_valid, miso_r, rise, fall, lead, trail, shifting, smp, lch, done, load, wr, cpha_use;
  assign cs_s = cs_q[sync_stages-1];
  assign sck_s = sck_q[sync_stages-1];
  assign mosi_s = mosi_q[sync_stages-1];
  assign rise = sck_s & ~sck_d;
  assign fall = ~sck_s & sck_d;
  assign lead = cpol_r ? fall : rise;
  assign trail = cpol_r ? rise : fall;
  assign shifting = (state == SHIFT) & ~cs_s;
  assign smp = shifting & (cpha_r ? trail : lead);
  assign lch = shifting & (cpha_r ? lead : trail);
  assign done = smp & (cnt + 6'd1 == fw_r);
  assign load = (state == LOAD) | done;
  assign fw_eff = (frame_width == 6'd0 || frame_width > 6'd32) ? 6'd32 : frame_width;
  assign fw_use = (state == LOAD) ? fw_eff : fw_r;
  assign cpha_use = (state == LOAD) ? cpha : cpha_r;
  assign sh = 6'd32 - fw_use;
  assign tx_word = buf_valid ? buf_data : 32'd0;
  assign tx_al = tx_word << sh;
  assign rx_word = {rx_sr, mosi_s};
  assign wr = s_axis_tvalid & s_axis_tready;
  assign s_axis_tready = ~buf_valid;
  assign miso = miso_r;
  assign busy = ~cs_s;
  // bring the asynchronous pins into the clk domain and keep a delayed sck for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= '1;
      sck_q <= '0;
      mosi_q <= '0;
      sck_d <= 1'b0;
    end else begin
      cs_q <= {cs_q[sync_stages-2:0], cs};
      sck_q <= {sck_q[sync_stages-2:0], sck};
      mosi_q <= {mosi_q[sync_stages-2:0], mosi};
      sck_d <= sck_s;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // deselect always wins; a fresh select spends one cycle in LOAD before shifting
  always_comb begin
    state_next = cs_s ? IDLE : (state == IDLE ? LOAD : SHIFT);
    miso_oe = state != IDLE;
  end
  // shift engine: config latch, rx sampling, tx launch; cpha=0 skips the launch edge that precedes a frame's first sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
      fw_r <= 6'd32;
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      miso_r <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      miso_r <= 1'b0;
    end else if (load) begin
      if (state == LOAD) begin
        cpol_r <= cpol;
        cpha_r <= cpha;
        fw_r <= fw_eff;
      end
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= cpha_use ? tx_al : {tx_al[30:0], 1'b0};
      miso_r <= cpha_use ? miso_r : tx_al[31];
    end else begin
      if (smp) begin
        rx_sr <= rx_word[30:0];
        cnt <= cnt + 6'd1;
      end
      if (lch && (cpha_r || cnt != 6'd0)) begin
        miso_r <= tx_sr[31];
        tx_sr <= {tx_sr[30:0], 1'b0};
      end
    end
  end
  // one-entry reply buffer; a frame-boundary load consumes the old entry before any new write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data <= '0;
    end else begin
      buf_valid <= wr | (buf_valid & ~load);
      if (wr) buf_data <= s_axis_tdata;
    end
  end
  // received-word register; a completed word is dropped while the held word is still unaccepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (done && !(m_axis_tvalid && !m_axis_tready)) begin
      m_axis_tdata <= rx_word;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
  // sticky record of any dropped word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overflow <= 1'b0;
    else if (done && m_axis_tvalid && !m_axis_tready) rx_overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized SPI master sessions against spi_slave with a word-level reference model
module tb_spi_slave;
  localparam int SS = 2;
  localparam int H = 10;
  logic clk = 1'b0, rst = 1'b1, cpol = 1'b0, cpha = 1'b0;
  logic [5:0] frame_width = 6'd8;
  logic [31:0] s_axis_tdata = '0, m_axis_tdata;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b1;
  logic cs = 1'b1, sck = 1'b0, mosi = 1'b0, miso, miso_oe, busy;
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
  logic rx_overflow;
`endif
  int tests = 0, fails = 0;
  logic [31:0] got_q[$];
  logic [31:0] bb_rep[3];
  logic [31:0] sent[3];
  logic [31:0] d, r, rd;
  logic p, h;
  logic [5:0] fw;
  int w;
  bit have;

  spi_slave #(.sync_stages(SS)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .frame_width(frame_width),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cs(cs), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
    .rx_overflow(rx_overflow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] mask(input int n);
    return n >= 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction

  task automatic xfer(input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        wait_clk(H);
        sck = ~sck;
        rx = {rx[30:0], miso};
        wait_clk(H);
        sck = ~sck;
      end else begin
        sck = ~sck;
        mosi = tx[i];
        wait_clk(H);
        sck = ~sck;
        rx = {rx[30:0], miso};
        wait_clk(H);
      end
    end
  endtask

  task automatic set_mode(input logic mp, input logic mh, input logic [5:0] mw);
    cpol = mp;
    cpha = mh;
    frame_width = mw;
    sck = mp;
    wait_clk(4);
  endtask

  task automatic push_reply(input logic [31:0] v);
    int n = 0;
    while (!s_axis_tready && n < 100) begin
      wait_clk(1);
      n++;
    end
    check("reply_ready", s_axis_tready, 1);
    s_axis_tdata = v;
    s_axis_tvalid = 1'b1;
    wait_clk(1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic select_dut();
    cs = 1'b0;
    wait_clk(H);
  endtask

  task automatic deselect_dut();
    cs = 1'b1;
    wait_clk(H);
  endtask

  task automatic expect_rx(input string tag, input logic [31:0] exp);
    check({tag, "_present"}, got_q.size() > 0, 1);
    if (got_q.size() > 0) check(tag, got_q.pop_front(), exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tready"}, s_axis_tready, 1);
    check({tag, "_mvalid"}, m_axis_tvalid, 0);
    check({tag, "_mdata"}, m_axis_tdata, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_oe"}, miso_oe, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
    check({tag, "_ovf"}, rx_overflow, 0);
`endif
  endtask

  initial begin
    bb_rep = '{32'h111, 32'h222, 32'h000};
    wait_clk(3);
    check_reset("reset");
    rst = 1'b0;
    wait_clk(3);

    set_mode(1'b0, 1'b0, 6'd8);
    push_reply(32'hA5);
    check("reply_full", s_axis_tready, 0);
    select_dut();
    check("sel_busy", busy, 1);
    check("sel_oe", miso_oe, 1);
    check("sel_tready", s_axis_tready, 1);
    xfer(8, 32'h3C, rd);
    deselect_dut();
    check("t1_miso", rd, 32'hA5);
    expect_rx("t1_rx", 32'h3C);
    check("t1_oe_off", miso_oe, 0);

    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 6'd32);
      push_reply(32'h1234_5678);
      select_dut();
      xfer(32, 32'hDEAD_BEEF, rd);
      deselect_dut();
      check("mode_miso", rd, 32'h1234_5678);
      expect_rx("mode_rx", 32'hDEAD_BEEF);
    end

    set_mode(1'b0, 1'b1, 6'd12);
    push_reply(32'h111);
    cs = 1'b0;
    wait_clk(6);
    push_reply(32'h222);
    wait_clk(H);
    for (int k = 0; k < 3; k++) begin
      sent[k] = $urandom & 32'hFFF;
      xfer(12, sent[k], rd);
      check("b2b_miso", rd, bb_rep[k]);
    end
    deselect_dut();
    for (int k = 0; k < 3; k++) expect_rx("b2b_rx", sent[k]);

    set_mode(1'b0, 1'b0, 6'd8);
    select_dut();
    xfer(5, $urandom, rd);
    cs = 1'b1;
    wait_clk(SS + 2);
    check("abort_oe", miso_oe, 0);
    wait_clk(H);
    check("abort_q", got_q.size(), 0);
    select_dut();
    xfer(8, 32'h81, rd);
    deselect_dut();
    expect_rx("abort_rx", 32'h81);
    check("abort_miso", rd, 0);

    m_axis_tready = 1'b0;
    select_dut();
    xfer(8, 32'h01, rd);
    check("ovf_v1", m_axis_tvalid, 1);
    check("ovf_d1", m_axis_tdata, 32'h01);
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
    check("ovf_flag0", rx_overflow, 0);
`endif
    xfer(8, 32'h02, rd);
    check("ovf_d2", m_axis_tdata, 32'h01);
    check("ovf_v2", m_axis_tvalid, 1);
`ifdef SPI_SLAVE_RX_OVERFLOW_EN
    check("ovf_flag1", rx_overflow, 1);
`endif
    deselect_dut();
    m_axis_tready = 1'b1;
    wait_clk(1);
    expect_rx("ovf_rx", 32'h01);
    check("ovf_q", got_q.size(), 0);

    select_dut();
    xfer(3, $urandom, rd);
    rst = 1'b1;
    cs = 1'b1;
    sck = cpol;
    #1;
    check_reset("midrst");
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    select_dut();
    xfer(8, 32'h5A, rd);
    deselect_dut();
    expect_rx("rst_rx", 32'h5A);
    check("rst_miso", rd, 0);

    for (int n = 0; n < 16; n++) begin
      p = 1'($urandom);
      h = 1'($urandom);
      fw = 6'($urandom);
      w = (fw == 6'd0 || fw > 6'd32) ? 32 : int'(fw);
      d = $urandom;
      r = $urandom;
      have = 1'($urandom);
      set_mode(p, h, fw);
      if (have) push_reply(r);
      select_dut();
      xfer(w, d, rd);
      deselect_dut();
      check("rnd_miso", rd, have ? (r & mask(w)) : 32'd0);
      expect_rx("rnd_rx", d & mask(w));
    end
    check("final_q", got_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
